// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and a parity helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Parity over the low nbits of d; odd mode inverts the XOR.
    function automatic logic parity_bit(input logic [7:0] d, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ d[i];
        end
        return (mode == int'(PAR_ODD)) ? ~p : p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; shared by TX and RX paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             push;
    logic             pop;

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frames go out back-to-back, LSB first.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    import uart_pkg::*;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = (STOP_BITS == 2);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [BW-1:0] bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          tick;
    logic          pop;
    logic          frame_end;
    logic          end_d;
    logic          line;
    logic [7:0]    fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (in_data),
        .wr_en   (in_valid),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign tick     = (timer == T_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, FIFO pop and the line level for the current bit.
    // The PARITY state is package-qualified because the parameter shares its name.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        frame_end = 1'b0;
        line      = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                line = 1'b0;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                line = shreg[0];
                if (tick && bit_idx == B_LAST)
                    state_nxt = (PARITY != 0) ? uart_pkg::PARITY : STOP;
            end
            uart_pkg::PARITY: begin
                line = par_bit;
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (tick && stop_idx == S_LAST) begin
                    frame_end = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timer, bit/stop counters and shift register; load happens on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            timer <= (state == IDLE || tick) ? '0 : timer + 1'b1;
            if (pop) begin
                shreg    <= fifo_rd;
                par_bit  <= parity_bit(fifo_rd, DATA_BITS, PARITY);
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else if (tick) begin
                if (state == DATA) begin
                    shreg <= {1'b0, shreg[7:1]};
                    if (bit_idx != B_LAST) bit_idx <= bit_idx + 1'b1;
                end
                if (state == STOP && stop_idx != S_LAST) stop_idx <= 1'b1;
            end
        end
    end

    // Registered outputs lag the FSM by one cycle; done lags frame end by two.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            end_d <= 1'b0;
            done  <= 1'b0;
        end else begin
            tx    <= line;
            busy  <= (state != IDLE);
            end_d <= frame_end;
            done  <= end_d;
        end
    end

endmodule
